timer_sched: RTL and testbench

- Round-robin scheduler that shares one timer_core instance among NUM_REQ requesters, each asking for a one-shot down-count delay.
- Arbitrates requests, then drives timer_core's configuration and control ports.
- Waits for the timer's irq and returns a 4-phase req/done handshake to the winner.
- Sits between the timer_core control ports and the software/hardware blocks that need timed delays.

---
 rtl/timer_sched.sv | 196 +++++++++++++++++++
 tb/tb_timer_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: shares one timer_core among NUM_REQ requesters with round-robin
// arbitration. Each winner gets a one-shot down-count of its requested delay, and
// a req/done 4-phase handshake reports completion.
// Optional build macro TIMER_SCHED_PRESCALE_EN adds per-requester prescaler values
// (pre_i) that are forwarded to timer_core while the owner's count is active.
module timer_sched #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 32,
  parameter int PRE_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] delay_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic                     tmr_en,
  output logic                     tmr_mode,
  output logic                     tmr_dir,
  output logic [CNT_W-1:0]         tmr_load_val,
  output logic                     tmr_load_cmd,
  output logic                     tmr_pre_en,
  output logic [PRE_W-1:0]         tmr_pre_val,
  input  logic                     tmr_irq
`ifdef TIMER_SCHED_PRESCALE_EN
  ,
  input  logic [NUM_REQ*PRE_W-1:0] pre_i
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [IDX_W-1:0]     last_grant_r, last_grant_s;
  logic [CNT_W-1:0]     delay_r, delay_s;
  logic [IDX_W:0]       pick_s;
  logic [CNT_W-1:0]     win_delay_s;
  logic                 owner_req_s;
  logic                 timing_s;
  logic [NUM_REQ-1:0]   grant_s, done_s;
  logic                 busy_s, en_s, load_cmd_s;
  logic [CNT_W-1:0]     load_val_s;

  // Returns {found, index} of the first set request after 'last', wrapping around.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = {(IDX_W+1){1'b0}};
    // Scan farthest-first so the nearest candidate after 'last' is kept.
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ((int'(last) + i) >= NUM_REQ) ? IDX_W'(int'(last) + i - NUM_REQ)
                                           : IDX_W'(int'(last) + i);
      res  = req[cand] ? {1'b1, cand} : res;
    end
    return res;
  endfunction

  assign tmr_mode = 1'b0;
  assign tmr_dir  = 1'b0;

  // Arbitration result and the winner's delay slice.
  always_comb begin
    pick_s      = rr_pick(req_i, last_grant_r);
    win_delay_s = {CNT_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      win_delay_s = (pick_s[IDX_W-1:0] == IDX_W'(k)) ? delay_i[k*CNT_W +: CNT_W] : win_delay_s;
    end
    owner_req_s = req_i[idx_r];
  end

  // Next-state decision and next values of every registered output.
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    delay_s      = delay_r;
    last_grant_s = last_grant_r;
    case (state_r)
      IDLE: begin
        if (pick_s[IDX_W]) begin
          idx_s        = pick_s[IDX_W-1:0];
          delay_s      = win_delay_s;
          last_grant_s = pick_s[IDX_W-1:0];
          state_s      = (win_delay_s != {CNT_W{1'b0}}) ? LOAD : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (!owner_req_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      RUN: begin
        // A dropped request cancels even when irq arrives on the same edge.
        if (!owner_req_s) begin
          state_s = IDLE;
        end else if (tmr_irq) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (!owner_req_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    timing_s   = (state_s == LOAD) || (state_s == RUN);
    grant_s    = (state_s != IDLE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_s) : {NUM_REQ{1'b0}};
    done_s     = (state_s == DONE) ? grant_s : {NUM_REQ{1'b0}};
    busy_s     = (state_s != IDLE);
    en_s       = (state_s == RUN);
    load_cmd_s = (state_s == LOAD);
    load_val_s = timing_s ? delay_s : {CNT_W{1'b0}};
  end

  // State, owner bookkeeping and registered handshake/timer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= {IDX_W{1'b0}};
      delay_r      <= {CNT_W{1'b0}};
      last_grant_r <= IDX_W'(NUM_REQ - 1);
      grant_o      <= {NUM_REQ{1'b0}};
      done_o       <= {NUM_REQ{1'b0}};
      busy_o       <= 1'b0;
      tmr_en       <= 1'b0;
      tmr_load_cmd <= 1'b0;
      tmr_load_val <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      delay_r      <= delay_s;
      last_grant_r <= last_grant_s;
      grant_o      <= grant_s;
      done_o       <= done_s;
      busy_o       <= busy_s;
      tmr_en       <= en_s;
      tmr_load_cmd <= load_cmd_s;
      tmr_load_val <= load_val_s;
    end
  end

`ifdef TIMER_SCHED_PRESCALE_EN
  logic [PRE_W-1:0] pre_r, pre_s, win_pre_s;

  // Winner's prescaler slice, captured together with its delay.
  always_comb begin
    win_pre_s = {PRE_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      win_pre_s = (pick_s[IDX_W-1:0] == IDX_W'(k)) ? pre_i[k*PRE_W +: PRE_W] : win_pre_s;
    end
    if ((state_r == IDLE) && pick_s[IDX_W]) begin
      pre_s = win_pre_s;
    end else begin
      pre_s = pre_r;
    end
  end

  // Latched prescaler and its forwarding while the count is loaded or running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r       <= {PRE_W{1'b0}};
      tmr_pre_en  <= 1'b0;
      tmr_pre_val <= {PRE_W{1'b0}};
    end else begin
      pre_r       <= pre_s;
      tmr_pre_en  <= timing_s && (pre_s != {PRE_W{1'b0}});
      tmr_pre_val <= timing_s ? pre_s : {PRE_W{1'b0}};
    end
  end
`else
  assign tmr_pre_en  = 1'b0;
  assign tmr_pre_val = {PRE_W{1'b0}};
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Testbench for timer_sched: directed scenarios with literal expectations plus
// randomized requester traffic compared every cycle against a behavioural model.
module tb_timer_sched;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int PW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_i = '0;
  logic [N*CW-1:0] delay_i = '0;
  logic            tmr_irq = 1'b0;
  logic [N-1:0]    grant_o, done_o;
  logic            busy_o, tmr_en, tmr_mode, tmr_dir, tmr_load_cmd, tmr_pre_en;
  logic [CW-1:0]   tmr_load_val;
  logic [PW-1:0]   tmr_pre_val;
`ifdef TIMER_SCHED_PRESCALE_EN
  logic [N*PW-1:0] pre_i = '0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit auto_irq = 1'b0;

  always #5 clk = ~clk;

  timer_sched #(.NUM_REQ(N), .CNT_W(CW), .PRE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .delay_i(delay_i),
    .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o),
    .tmr_en(tmr_en), .tmr_mode(tmr_mode), .tmr_dir(tmr_dir),
    .tmr_load_val(tmr_load_val), .tmr_load_cmd(tmr_load_cmd),
    .tmr_pre_en(tmr_pre_en), .tmr_pre_val(tmr_pre_val), .tmr_irq(tmr_irq)
`ifdef TIMER_SCHED_PRESCALE_EN
    , .pre_i(pre_i)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Owner (-1 = none), its latched delay/prescale, edges since grant, completion.
  int            m_owner = -1;
  int            m_last  = N - 1;
  int            m_age   = 0;
  bit            m_done  = 1'b0;
  logic [CW-1:0] m_delay = '0;
  logic [PW-1:0] m_pre   = '0;

  task automatic model_reset();
    m_owner = -1; m_last = N - 1; m_age = 0; m_done = 1'b0; m_delay = '0; m_pre = '0;
  endtask

  // Advance the model by one clock edge using the inputs that edge will sample.
  task automatic model_step();
    if (m_owner < 0) begin
      for (int s = 1; s <= N; s++) begin
        if (m_owner < 0 && req_i[(m_last + s) % N]) m_owner = (m_last + s) % N;
      end
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_delay = delay_i[m_owner*CW +: CW];
`ifdef TIMER_SCHED_PRESCALE_EN
        m_pre   = pre_i[m_owner*PW +: PW];
`else
        m_pre   = '0;
`endif
        m_age   = 0;
        m_done  = (m_delay == 0);
      end
    end else if (!req_i[m_owner]) begin
      m_owner = -1;
      m_done  = 1'b0;
    end else begin
      if (!m_done && m_age >= 1 && tmr_irq) m_done = 1'b1;
      m_age++;
    end
  endtask

  // Compare process: every falling edge after the first reset.
  initial begin
    logic [N-1:0] oh;
    bit live;
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      oh   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      live = (m_owner >= 0) && !m_done;
      chk("m_grant", grant_o, oh);
      chk("m_done", done_o, m_done ? oh : '0);
      chk("m_busy", busy_o, m_owner >= 0);
      chk("m_load_cmd", tmr_load_cmd, live && m_age == 0);
      chk("m_en", tmr_en, live && m_age >= 1);
      chk("m_load_val", tmr_load_val, live ? m_delay : '0);
      chk("m_mode_dir", {tmr_mode, tmr_dir}, 2'b00);
      chk("m_pre_en", tmr_pre_en, live && (m_pre != 0));
      chk("m_pre_val", tmr_pre_val, live ? m_pre : '0);
      if (rst_n) model_step();
    end
  end

  // ---------------- randomized stimulus agents ----------------
  int t_cnt = 0;

  task automatic rand_cycle();
    for (int k = 0; k < N; k++) begin
      if (!req_i[k]) begin
        if ($urandom_range(0, 3) == 0) begin
          delay_i[k*CW +: CW] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 12));
`ifdef TIMER_SCHED_PRESCALE_EN
          pre_i[k*PW +: PW] = ($urandom_range(0, 1) == 0) ? '0 : PW'($urandom_range(1, 500));
`endif
          req_i[k] = 1'b1;
        end
      end else begin
        if (done_o[k] && $urandom_range(0, 1) == 0) req_i[k] = 1'b0;
        else if ($urandom_range(0, 39) == 0) req_i[k] = 1'b0;
        if ($urandom_range(0, 9) == 0) delay_i[k*CW +: CW] = CW'($urandom_range(0, 12));
      end
    end
    if (tmr_load_cmd) t_cnt = int'(tmr_load_val);
    else if (tmr_en && t_cnt != 0) t_cnt--;
    tmr_irq = (tmr_en && t_cnt == 0) || ($urandom_range(0, 15) == 0);
  endtask

  // Bounded wait: sel 0 = any grant, 1 = tmr_en, 2 = any done.
  task automatic wait_for(input int sel, input string name);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      hit = (sel == 0) ? (grant_o != 0) : (sel == 1) ? tmr_en : (done_o != 0);
      if (!hit) step();
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL %s: timeout waiting, got 0, expected 1", name);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int order [5];
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_grant", grant_o, 4'b0000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_en", tmr_en, 1'b0);

    // Single request with delay 10.
    delay_i[0*CW +: CW] = 32'd10;
    req_i = 4'b0001;
    step();
    chk("single_grant", grant_o, 4'b0001);
    chk("single_load_cmd", tmr_load_cmd, 1'b1);
    chk("single_load_val", tmr_load_val, 32'd10);
    chk("single_en_load", tmr_en, 1'b0);
    step();
    chk("single_en_run", tmr_en, 1'b1);
    chk("single_cmd_run", tmr_load_cmd, 1'b0);
    step(); step();
    tmr_irq = 1'b1;
    step();
    tmr_irq = 1'b0;
    chk("single_done", done_o, 4'b0001);
    chk("single_en_done", tmr_en, 1'b0);
    step();
    chk("single_done_held", done_o, 4'b0001);
    req_i = 4'b0000;
    step();
    chk("single_idle_busy", busy_o, 1'b0);
    chk("single_idle_grant", grant_o, 4'b0000);

    // Zero delay completes without touching the timer.
    delay_i[1*CW +: CW] = 32'd0;
    req_i = 4'b0010;
    step();
    chk("zero_grant", grant_o, 4'b0010);
    chk("zero_done", done_o, 4'b0010);
    chk("zero_load_cmd", tmr_load_cmd, 1'b0);
    chk("zero_en", tmr_en, 1'b0);
    req_i = 4'b0000;
    step();

    // Cancel five cycles into RUN.
    delay_i[2*CW +: CW] = 32'd100;
    req_i = 4'b0100;
    step(); step();
    chk("cancel_en_run", tmr_en, 1'b1);
    step(); step(); step(); step();
    req_i = 4'b0000;
    step();
    chk("cancel_en", tmr_en, 1'b0);
    chk("cancel_grant", grant_o, 4'b0000);
    chk("cancel_done", done_o, 4'b0000);
    chk("cancel_busy", busy_o, 1'b0);

    // irq and cancel on the same edge: cancel wins, next pending wins afterwards.
    delay_i[3*CW +: CW] = 32'd5;
    delay_i[0*CW +: CW] = 32'd7;
    req_i = 4'b1001;
    step();
    chk("coll_grant", grant_o, 4'b1000);
    step(); step();
    tmr_irq = 1'b1;
    req_i = 4'b0001;
    step();
    tmr_irq = 1'b0;
    chk("coll_done", done_o, 4'b0000);
    chk("coll_grant_clr", grant_o, 4'b0000);
    step();
    chk("coll_next_grant", grant_o, 4'b0001);
    req_i = 4'b0000;
    step();

    // Async reset while running, then requester 0 wins first.
    delay_i[2*CW +: CW] = 32'd50;
    req_i = 4'b0100;
    step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", grant_o, 4'b0000);
    chk("arst_en", tmr_en, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    for (int k = 0; k < N; k++) delay_i[k*CW +: CW] = 32'd3;
    req_i = 4'b1111;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("arst_first", grant_o, 4'b0001);

    // Round-robin with all requesters held; each re-raises after completing.
    for (int g = 0; g < 5; g++) begin
      wait_for(0, "rr_grant");
      order[g] = -1;
      for (int k = 0; k < N; k++) if (grant_o[k]) order[g] = k;
      wait_for(1, "rr_en");
      tmr_irq = 1'b1;
      step();
      tmr_irq = 1'b0;
      wait_for(2, "rr_done");
      if (order[g] >= 0) req_i[order[g]] = 1'b0;
      step();
      req_i = 4'b1111;
    end
    for (int g = 0; g < 5; g++) chk($sformatf("rr_order%0d", g), order[g], exp_order[g]);
    req_i = 4'b0000;
    step(); step();

    // Randomized traffic against the model.
    auto_irq = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      step();
    end
    req_i = 4'b0000;
    tmr_irq = 1'b0;
    step(); step(); step();
    chk("end_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
